// File: rtl/arith_chain_pkg.sv
// Shared constants and the final-operation mode encoding for the arith_chain pipeline.
package arith_chain_pkg;

  localparam int unsigned IN_W_DEF  = 5;
  localparam int unsigned OUT_W_DEF = 37;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MODE_W    = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_MUL = 2'b10,
    MODE_XOR = 2'b11
  } mode_e;

endpackage

// File: rtl/arith_chain_slice.sv
// Generic valid/ready register slice with synchronous flush of the valid flag.
module arith_chain_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready_c,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Load when empty or when the held content leaves this cycle.
  assign up_ready_c = !valid_q || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (up_ready_c) begin
        valid_q <= up_valid;
      end
      if (up_ready_c && up_valid && !flush) begin
        data_q <= up_data;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/arith_chain_pipe.sv
// Three-stage arithmetic chain x -> t0 -> t1 -> r with valid/ready flow control.
// Define ARITH_CHAIN_SAT_EN to clamp the result into [0, 2^OUT_W-1] instead of wrapping.
module arith_chain_pipe
  import arith_chain_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [IN_W-1:0]   in_data,
  input  logic [MODE_W-1:0] in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count
);

  localparam int unsigned T1_W = 2 * IN_W - 1;
  localparam int unsigned R_W  = 3 * IN_W + 1;
  localparam int unsigned P1_W = MODE_W + 2 * IN_W;
  localparam int unsigned P2_W = MODE_W + IN_W + T1_W;

  logic [IN_W-1:0]  sq_c;
  logic [IN_W-1:0]  tri_c;
  logic [IN_W-1:0]  t0_c;
  logic [P1_W-1:0]  p1_c;
  logic [P1_W-1:0]  q1;
  logic             v1;
  logic             rdy2;

  // S1: t0 from x alone; products are taken modulo 2^IN_W by width.
  always_comb begin
    sq_c  = in_data * in_data;
    tri_c = in_data * IN_W'(3);
    if (in_data[IN_W-2]) begin
      t0_c = tri_c;
    end else begin
      t0_c = sq_c & in_data;
    end
    p1_c = {in_mode, in_data, t0_c};
  end

  arith_chain_slice #(.W(P1_W)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .up_valid   (in_valid),
    .up_data    (p1_c),
    .up_ready_c (in_ready),
    .dn_valid   (v1),
    .dn_data    (q1),
    .dn_ready   (rdy2)
  );

  logic [IN_W-1:0]   x1;
  logic [IN_W-1:0]   t0_1;
  logic [MODE_W-1:0] m1;
  logic [T1_W-1:0]   t1_c;
  logic [P2_W-1:0]   p2_c;
  logic [P2_W-1:0]   q2;
  logic              v2;
  logic              rdy3;

  // S2: exact t1 = x * (t0 >> 1); x is consumed here.
  always_comb begin
    m1   = q1[P1_W-1:2*IN_W];
    x1   = q1[2*IN_W-1:IN_W];
    t0_1 = q1[IN_W-1:0];
    t1_c = T1_W'(x1) * T1_W'(t0_1[IN_W-1:1]);
    p2_c = {m1, t0_1, t1_c};
  end

  arith_chain_slice #(.W(P2_W)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .up_valid   (v1),
    .up_data    (p2_c),
    .up_ready_c (rdy2),
    .dn_valid   (v2),
    .dn_data    (q2),
    .dn_ready   (rdy3)
  );

  mode_e                  m2_c;
  logic [IN_W-1:0]        t0_2;
  logic [T1_W-1:0]        t1_2;
  logic signed [R_W-1:0]  a_c;
  logic signed [R_W-1:0]  b_c;
  logic signed [R_W-1:0]  r_c;
  logic [OUT_W-1:0]       res_c;

`ifdef ARITH_CHAIN_SAT_EN
  localparam int unsigned WIDE_W = ((R_W > OUT_W) ? R_W : OUT_W) + 2;
  localparam logic [WIDE_W-1:0] SAT_MAX = WIDE_W'({OUT_W{1'b1}});
  logic signed [WIDE_W-1:0] r_wide_c;
`endif

  // S3: exact signed result, then wrap or clamp into OUT_W bits.
  always_comb begin
    m2_c = mode_e'(q2[P2_W-1:P2_W-MODE_W]);
    t0_2 = q2[IN_W+T1_W-1:T1_W];
    t1_2 = q2[T1_W-1:0];
    a_c  = R_W'(t1_2);
    b_c  = R_W'(t0_2);
    r_c  = '0;
    case (m2_c)
      MODE_ADD: r_c = a_c + b_c;
      MODE_SUB: r_c = a_c - b_c;
      MODE_MUL: r_c = a_c * b_c;
      MODE_XOR: r_c = a_c ^ b_c;
      default:  r_c = '0;
    endcase
`ifdef ARITH_CHAIN_SAT_EN
    r_wide_c = WIDE_W'(r_c);
    if (r_wide_c[WIDE_W-1]) begin
      res_c = '0;
    end else if (r_wide_c > $signed(SAT_MAX)) begin
      res_c = '1;
    end else begin
      res_c = OUT_W'(r_wide_c);
    end
`else
    res_c = OUT_W'(r_c);
`endif
  end

  arith_chain_slice #(.W(OUT_W)) u_s3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .up_valid   (v2),
    .up_data    (res_c),
    .up_ready_c (rdy3),
    .dn_valid   (out_valid),
    .dn_data    (out_data),
    .dn_ready   (out_ready)
  );

  logic [CNT_W-1:0] cnt_q;

  // Completed output transfers; flush leaves this alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_count = cnt_q;

endmodule

// File: tb/tb_arith_chain_pipe.sv
// Scoreboard bench for arith_chain_pipe: OUT_W=37 and OUT_W=8 instances share one stimulus stream.
module tb_arith_chain_pipe;
  import arith_chain_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [4:0]  in_data;
  logic [1:0]  in_mode;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready8;
  logic [36:0] out_data;
  logic [7:0]  out_data8;
  logic        out_valid;
  logic        out_valid8;
  logic        out_ready = 1'b1;
  logic [15:0] out_count;
  logic [15:0] out_count8;

  arith_chain_pipe #(.IN_W(5), .OUT_W(37)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count)
  );

  arith_chain_pipe #(.IN_W(5), .OUT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready8), .out_data(out_data8), .out_valid(out_valid8),
    .out_ready(out_ready), .out_count(out_count8)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint e37;
    longint e8;
    int     acc;
    bit     chk;
  } exp_t;

  exp_t   sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     n_done  = 0;
  bit     hold    = 1'b0;
  bit     bp_on   = 1'b0;
  int     bp_lo   = 0;
  int     bp_hi   = 0;
  bit     saw_stall = 1'b0;
  bit     prev_hold = 1'b0;
  logic [36:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: forced low by hold or by the backpressure window.
  always @(posedge clk) begin
    #2;
    out_ready = !(hold || (bp_on && cyc >= bp_lo && cyc <= bp_hi));
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference for IN_W=5 in plain integer arithmetic.
  function automatic longint model_r(input int x, input int m);
    int t0;
    int t1;
    if ((x & 8) != 0) t0 = (3 * x) % 32;
    else              t0 = ((x * x) % 32) & x;
    t1 = x * (t0 / 2);
    case (m)
      0:       return longint'(t1 + t0);
      1:       return longint'(t1 - t0);
      2:       return longint'(t1 * t0);
      default: return longint'(t1 ^ t0);
    endcase
  endfunction

  function automatic longint fit(input longint r, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef ARITH_CHAIN_SAT_EN
    if (r < 0) return 0;
    if (r > mx) return mx;
    return r;
`else
    return r & mx;
`endif
  endfunction

  task automatic send(input int x, input int m, input longint e37, input longint e8,
                      input bit chk, input bit push);
    int   guard;
    exp_t e;
    in_valid = 1'b1;
    in_data  = 5'(x);
    in_mode  = 2'(m);
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      saw_stall = 1'b1;
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", guard);
    end else if (push) begin
      e.e37 = e37;
      e.e8  = e8;
      e.acc = cyc;
      e.chk = chk;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and tracks the count.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_done    = 0;
      prev_hold = 1'b0;
    end else begin
      check("out_count", longint'(out_count), longint'(n_done % 65536));
      if (prev_hold && out_valid) check("hold_stable", longint'(out_data), longint'(prev_data));
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output", out_data);
        end else begin
          e = sb.pop_front();
          check("data_w37", longint'(out_data), e.e37);
          check("data_w8", longint'(out_data8), e.e8);
          check("valid_w8", longint'(out_valid8), 1);
          if (e.chk) check("latency", longint'(cyc - e.acc), 3);
        end
        n_done++;
      end
    end
  end

  int     tx [10] = '{10, 10, 10, 10, 3, 31, 31, 31, 31, 8};
  int     tm [10] = '{0, 1, 2, 3, 1, 0, 1, 2, 3, 1};
`ifdef ARITH_CHAIN_SAT_EN
  longint te37 [10] = '{180, 120, 4500, 136, 0, 463, 405, 12586, 431, 72};
  longint te8  [10] = '{180, 120, 255, 136, 0, 255, 255, 255, 255, 72};
`else
  longint te37 [10] = '{180, 120, 4500, 136, 64'h1F_FFFF_FFFF, 463, 405, 12586, 431, 72};
  longint te8  [10] = '{180, 120, 148, 136, 255, 207, 149, 42, 175, 72};
`endif

  initial begin
    int     base;
    longint r;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_count", longint'(out_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back-to-back with out_ready high.
    for (int i = 0; i < 10; i++) send(tx[i], tm[i], te37[i], te8[i], 1'b1, 1'b1);
    wait_drain();

    // Ten back-to-back inputs with out_ready low for relative cycles 4..7.
    saw_stall = 1'b0;
    base  = cyc;
    bp_lo = base + 4;
    bp_hi = base + 7;
    bp_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = model_r((i * 3 + 1) % 32, i % 4);
      send((i * 3 + 1) % 32, i % 4, fit(r, 37), fit(r, 8), 1'b0, 1'b1);
    end
    wait_drain();
    bp_on = 1'b0;
    @(negedge clk);
    check("bp_stall_seen", longint'(saw_stall), 1);
    check("bp_out_count", longint'(out_count), 20);

    // Flush with three held in flight; an input offered during flush is dropped.
    hold = 1'b1;
    @(negedge clk);
    send(5, 0, 0, 0, 1'b0, 1'b0);
    send(7, 2, 0, 0, 1'b0, 1'b0);
    send(12, 3, 0, 0, 1'b0, 1'b0);
    check("flush_pre_valid", longint'(out_valid), 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd3;
    in_mode  = 2'd1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", longint'(out_valid), 0);
    hold = 1'b0;
    @(negedge clk);
    send(10, 0, 180, 180, 1'b1, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("flush_out_count", longint'(out_count), 21);

    // Asynchronous reset with a full, stalled pipeline.
    hold = 1'b1;
    @(negedge clk);
    send(1, 0, 0, 0, 1'b0, 1'b0);
    send(2, 1, 0, 0, 1'b0, 1'b0);
    send(9, 2, 0, 0, 1'b0, 1'b0);
    check("pre_rst_valid", longint'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_count", longint'(out_count), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_out_data", longint'(out_data), 0);
    sb.delete();
    hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(10, 3, 136, 136, 1'b1, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("post_rst_out_count", longint'(out_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/arith_chain_pipe.md
ARITH_CHAIN_PIPE -- requirements
Module: arith_chain_pipe

Interface
REQ-001 Parameter IN_W, default 5, operand width; legal range 3..16.
REQ-002 Parameter OUT_W, default 37, result width; legal range 2..64.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous clear of all pipeline valid flags.
REQ-006 in_data  input  IN_W  unsigned operand x.
REQ-007 in_mode  input  2  final operation: 00 ADD, 01 SUB, 10 MUL, 11 XOR.
REQ-008 in_valid / in_ready  input / output  1 each  upstream handshake; a transfer occurs when both are high on a clock edge.
REQ-009 out_data  output  OUT_W  result.
REQ-010 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-011 out_count  output  16  number of completed output transfers, wraps modulo 2^16.

Function
REQ-012 Pipeline SHALL have three register stages S1..S3; latency 3 cycles from input transfer to out_valid when there is no backpressure; throughput 1 per cycle.
REQ-013 S1 SHALL compute t0 (IN_W bits): if x[IN_W-2]=1, t0 = (3*x) mod 2^IN_W; otherwise t0 = (x*x mod 2^IN_W) & x.
REQ-014 S2 SHALL compute t1 = x * t0[IN_W-1:1], unsigned, 2*IN_W-1 bits, exact; x, t0 and mode travel with the stage.
REQ-015 S3 SHALL compute r, exact and signed at 3*IN_W+1 bits: ADD t1+t0, SUB t1-t0, MUL t1*t0, XOR t1^t0 (t0 zero-extended).
REQ-016 Without saturation, out_data SHALL be r mod 2^OUT_W (two's complement wrap).
REQ-017 Each stage SHALL load when it is empty or its content advances that cycle; in_ready = !v1 | S1 advances; S3 advances when out_ready=1.
REQ-018 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 flush=1 SHALL clear v1..v3 at the next edge and SHALL drop any input transfer in that cycle; out_count is unaffected.
REQ-020 out_count SHALL increment on every cycle with out_valid & out_ready, and wraps 0xFFFF -> 0x0000.
REQ-021 Simultaneous fill and drain of a full pipeline SHALL neither lose nor duplicate data.

Reset
REQ-022 While rst_n=0: v1..v3=0, out_valid=0, in_ready=1 (combinational), out_data=0, out_count=0; all data registers = 0.
REQ-023 A reset asserted mid-operation SHALL discard all in-flight operands; the first transfer after release completes after 3 cycles.

Configuration
REQ-024 Macro ARITH_CHAIN_SAT_EN: when defined, S3 SHALL clamp r to 0 if r<0 and to 2^OUT_W-1 if r >= 2^OUT_W; when undefined, wrap per REQ-016.

Structure
REQ-025 Package arith_chain_pkg SHALL hold the mode enum (ADD/SUB/MUL/XOR), IN_W/OUT_W defaults and the count width constant 16.
REQ-026 Sub-module arith_chain_slice SHALL implement one generic valid/ready register slice with flush, instantiated three times.

Verification
REQ-027 IN_W=5, OUT_W=37, x=10, modes ADD/SUB/MUL/XOR, out_ready=1 -> out_data 180/120/4500/136, each 3 cycles after its input.
REQ-028 x=3, SUB: wrap build -> 0x1F_FFFF_FFFF; ARITH_CHAIN_SAT_EN build -> 0.
REQ-029 OUT_W=8, x=10, MUL -> wrap 148; saturating 255.
REQ-030 Back-to-back 10 inputs with out_ready low for cycles 4..7 -> in_ready low once 3 are held, then all 10 results in order, none lost, out_count=10.
REQ-031 flush with 3 in flight, then x=10 ADD -> only 180 appears, out_count increments by 1.
REQ-032 rst_n pulsed low mid-stream -> out_valid=0 and out_count=0 immediately; the next input yields a result 3 cycles after acceptance.
